// File: rtl/rf_writeback_queue_pkg.sv
// rtl/rf_writeback_queue_pkg.sv - shared types and constants for the register-file writeback queue
package rf_wb_pkg;
    localparam int RF_DEPTH  = 4;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    localparam logic [RF_ADDR_W-1:0] RF_ZERO_ADDR = '0;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/rf_writeback_queue_if.sv
// rtl/rf_writeback_queue_if.sv - writeback queue bus; RF_WB_FWD_EN adds the forwarding signals
interface rf_wb_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
);
    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_data;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic [ADDR_W-1:0] write_addr_rf;
    logic [DATA_W-1:0] write_data_rf;
    logic [ADDR_W-1:0] rs1addr_q;
    logic [ADDR_W-1:0] rs2addr_q;
    logic              rs1_pending;
    logic              rs2_pending;
    logic [CNT_W-1:0]  q_count;
`ifdef RF_WB_FWD_EN
    logic              rs1_fwd_valid;
    logic [DATA_W-1:0] rs1_fwd_data;
    logic              rs2_fwd_valid;
    logic [DATA_W-1:0] rs2_fwd_data;

    modport slave (
        input  lsu_valid, lsu_addr, lsu_data, alu_valid, alu_addr, alu_data, rs1addr_q, rs2addr_q,
        output lsu_ready, alu_ready, write_addr_rf, write_data_rf, rs1_pending, rs2_pending, q_count,
               rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data
    );
    modport master (
        output lsu_valid, lsu_addr, lsu_data, alu_valid, alu_addr, alu_data, rs1addr_q, rs2addr_q,
        input  lsu_ready, alu_ready, write_addr_rf, write_data_rf, rs1_pending, rs2_pending, q_count,
               rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data
    );
`else
    modport slave (
        input  lsu_valid, lsu_addr, lsu_data, alu_valid, alu_addr, alu_data, rs1addr_q, rs2addr_q,
        output lsu_ready, alu_ready, write_addr_rf, write_data_rf, rs1_pending, rs2_pending, q_count
    );
    modport master (
        output lsu_valid, lsu_addr, lsu_data, alu_valid, alu_addr, alu_data, rs1addr_q, rs2addr_q,
        input  lsu_ready, alu_ready, write_addr_rf, write_data_rf, rs1_pending, rs2_pending, q_count
    );
`endif
endinterface

// File: rtl/rf_writeback_queue_match.sv
// rtl/rf_writeback_queue_match.sv - per-read-port CAM over queued destinations; RF_WB_FWD_EN adds youngest-match data
module rf_wb_match
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH
) (
    input  logic [RF_ADDR_W-1:0]       addrs [DEPTH],
    input  logic [DEPTH-1:0]           occ,
`ifdef RF_WB_FWD_EN
    input  logic [RF_DATA_W-1:0]       datas [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [RF_DATA_W-1:0]       fwd_data,
`endif
    input  logic [RF_ADDR_W-1:0]       rs,
    output logic                       pending
);
    localparam int PTR_W = $clog2(DEPTH);

`ifdef RF_WB_FWD_EN
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last hit leaves the youngest data.
    always_comb begin
        pending  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (occ[idx] && (addrs[idx] == rs) && (rs != RF_ZERO_ADDR)) begin
                pending  = 1'b1;
                fwd_data = datas[idx];
            end
        end
    end
`else
    always_comb begin
        pending = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (occ[k] && (addrs[k] == rs) && (rs != RF_ZERO_ADDR)) begin
                pending = 1'b1;
            end
        end
    end
`endif
endmodule

// File: rtl/rf_writeback_queue.sv
// rtl/rf_writeback_queue.sv - dual-source writeback queue draining one register-file write per cycle
// Optional forwarding outputs are enabled by defining RF_WB_FWD_EN.
module rf_writeback_queue
    import rf_wb_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH,
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic    clk,
    input  logic    rst,
    rf_wb_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    wb_entry_t entries_q [DEPTH];
    wb_entry_t entries_d [DEPTH];
    ptr_t      wr_ptr_q, wr_ptr_d;
    ptr_t      rd_ptr_q, rd_ptr_d;
    cnt_t      count_q, count_d;
    cnt_t      free;
    ptr_t      alu_slot;
    logic      lsu_store, alu_store, deq;
    logic [DEPTH-1:0] occ;
    logic [RF_ADDR_W-1:0] addrs [DEPTH];
    logic      rs1_pending, rs2_pending;

    // Readiness uses the registered count only; a same-cycle retire does not free a slot.
    assign free          = cnt_t'(DEPTH) - count_q;
    assign bus.lsu_ready = !rst && (free >= cnt_t'(1));
    assign bus.alu_ready = !rst && ((free >= cnt_t'(2)) || ((free >= cnt_t'(1)) && !bus.lsu_valid));

    // Writes to x0 complete the handshake but never occupy a slot.
    assign lsu_store = bus.lsu_valid && bus.lsu_ready && (bus.lsu_addr != RF_ZERO_ADDR);
    assign alu_store = bus.alu_valid && bus.alu_ready && (bus.alu_addr != RF_ZERO_ADDR);
    assign deq       = (count_q != '0);
    assign alu_slot  = wr_ptr_q + ptr_t'(lsu_store);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
        end
        if (lsu_store) begin
            entries_d[wr_ptr_q] = '{addr: bus.lsu_addr, data: bus.lsu_data};
        end
        if (alu_store) begin
            entries_d[alu_slot] = '{addr: bus.alu_addr, data: bus.alu_data};
        end
        wr_ptr_d = wr_ptr_q + ptr_t'(lsu_store) + ptr_t'(alu_store);
        rd_ptr_d = rd_ptr_q + ptr_t'(deq);
        count_d  = count_q + cnt_t'(lsu_store) + cnt_t'(alu_store) - cnt_t'(deq);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Slot i is live when its distance from the head is below the count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            occ[i]   = {1'b0, ptr_t'(i) - rd_ptr_q} < count_q;
            addrs[i] = entries_q[i].addr;
        end
    end

    assign bus.write_addr_rf = deq ? ADDR_W'(entries_q[rd_ptr_q].addr) : '0;
    assign bus.write_data_rf = deq ? DATA_W'(entries_q[rd_ptr_q].data) : '0;
    assign bus.q_count       = count_q;
    assign bus.rs1_pending   = rs1_pending;
    assign bus.rs2_pending   = rs2_pending;

`ifdef RF_WB_FWD_EN
    logic [RF_DATA_W-1:0] datas [DEPTH];
    logic [RF_DATA_W-1:0] rs1_fwd_data, rs2_fwd_data;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            datas[i] = entries_q[i].data;
        end
    end

    assign bus.rs1_fwd_valid = rs1_pending;
    assign bus.rs2_fwd_valid = rs2_pending;
    assign bus.rs1_fwd_data  = DATA_W'(rs1_fwd_data);
    assign bus.rs2_fwd_data  = DATA_W'(rs2_fwd_data);
`endif

    rf_wb_match #(.DEPTH(DEPTH)) u_match_rs1 (
        .addrs    (addrs),
        .occ      (occ),
`ifdef RF_WB_FWD_EN
        .datas    (datas),
        .rd_ptr   (rd_ptr_q),
        .fwd_data (rs1_fwd_data),
`endif
        .rs       (RF_ADDR_W'(bus.rs1addr_q)),
        .pending  (rs1_pending)
    );

    rf_wb_match #(.DEPTH(DEPTH)) u_match_rs2 (
        .addrs    (addrs),
        .occ      (occ),
`ifdef RF_WB_FWD_EN
        .datas    (datas),
        .rd_ptr   (rd_ptr_q),
        .fwd_data (rs2_fwd_data),
`endif
        .rs       (RF_ADDR_W'(bus.rs2addr_q)),
        .pending  (rs2_pending)
    );
endmodule
